fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word address of the request; equals pc.
REQ-006 imem_ack  input  1  memory has rdata valid this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 instr  output  32  captured instruction; instr[31:26] drives the main controller opcode.
REQ-009 instr_valid  output  1  instr is valid for decode/execute.
REQ-010 exec_done  input  1  datapath finished executing instr; Branch/Zero/Jump valid this cycle.
REQ-011 Branch  input  1  controller branch signal (beq).
REQ-012 Zero  input  1  ALU zero flag.
REQ-013 Jump  input  1  controller jump signal.
REQ-014 pc  output  32  address of current instruction.
REQ-015 pc_plus4  output  32  pc + 4, modulo 2^32, combinational from pc.
REQ-016 retired_cnt  output  32  count of completed instructions.

Function
REQ-017 States: FETCH, ISSUE; 1-bit state register.
REQ-018 FETCH: imem_req=1, instr_valid=0; imem_ack=1 same or any later cycle -> instr<=imem_rdata, next state ISSUE.
REQ-019 imem_req stays asserted every FETCH cycle until imem_ack; no timeout.
REQ-020 ISSUE: imem_req=0, instr_valid=1, instr held stable; imem_ack ignored.
REQ-021 ISSUE with exec_done=1: pc<=next_pc, retired_cnt<=retired_cnt+1, next state FETCH; exec_done=0 -> remain ISSUE, no change.
REQ-022 exec_done outside ISSUE ignored.
REQ-023 next_pc priority: Jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch=1 and Zero=1 -> pc_plus4 + (sign_extend(instr[15:0]) << 2); else pc_plus4.
REQ-024 Jump and Branch both 1: jump target taken.
REQ-025 Branch=1, Zero=0: pc_plus4 taken.
REQ-026 All pc arithmetic 32-bit, wrap modulo 2^32 (pc=32'hFFFF_FFFC, sequential -> 32'h0000_0000).
REQ-027 pc[1:0] always 2'b00; RESET_PC[1:0] required 2'b00.
REQ-028 retired_cnt wraps 32'hFFFF_FFFF -> 0.
REQ-029 Minimum instruction period 2 cycles (ack in first FETCH cycle, exec_done in first ISSUE cycle).

Reset
REQ-030 rst_n=0 asynchronously: state=FETCH, pc=RESET_PC, instr=32'h0000_0000, retired_cnt=0.
REQ-031 During reset: imem_req=0, instr_valid=0; first request on first clock edge after rst_n rises.
REQ-032 Reset mid-FETCH or mid-ISSUE abandons the transaction; a pending ack is not captured.

Structure
REQ-033 Shared package holds state enum (FETCH, ISSUE), RESET_PC default, opcode field positions [31:26], imm [15:0], target [25:0].
REQ-034 One sub-module: npc_calc (combinational next_pc from pc, instr, Branch, Zero, Jump); rest in fetch_unit.

Verification
REQ-035 Reset, ack held 1, exec_done held 1, no branch -> imem_addr 32'h3000, 32'h3004, 32'h3008 every 2 cycles; retired_cnt 1,2,3.
REQ-036 pc=32'h3000, instr=32'h1000_FFFF, Branch=1, Zero=1 at exec_done -> pc=32'h3000; Zero=0 -> pc=32'h3004.
REQ-037 pc=32'h3010, instr=32'h0800_0C00, Jump=1, Branch=1, Zero=1 -> pc=32'h0000_3000.
REQ-038 imem_ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr constant, instr_valid=0 throughout, then instr=imem_rdata.
REQ-039 RESET_PC=32'hFFFF_FFFC, sequential retire -> pc=32'h0000_0000, pc_plus4=32'h0000_0004.
REQ-040 rst_n pulsed low in ISSUE with exec_done=1 -> pc=RESET_PC, retired_cnt=0, instr_valid=0 immediately, no increment.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// default reset address and instruction field positions.
package fetch_unit_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection: jump target, taken branch or pc + 4.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] target_field,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] imm_ext;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pc_plus4      = pc + 32'd4;
    assign imm_ext       = sign_extend16(target_field[IMM_MSB:IMM_LSB]);
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], target_field[TARGET_MSB:TARGET_LSB], 2'b00};

    // Jump wins over a taken branch; an untaken branch falls through
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at pc, holds it for execution
// and advances pc once the datapath reports completion.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_cnt
);

    state_t      state_reg;
    state_t      state_next;
    logic        active_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] retired_reg;
    logic [31:0] next_pc;
    logic        capture;
    logic        retire;

    npc_calc u_npc_calc (
        .pc           (pc_reg),
        .target_field (instr_reg[TARGET_MSB:TARGET_LSB]),
        .branch       (Branch),
        .zero         (Zero),
        .jump         (Jump),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    // active_reg keeps the request low until the first edge after reset
    // releases, so an ack present during that cycle is never captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        case (state_reg)
            FETCH: begin
                imem_req = active_reg;
                if (active_reg && imem_ack) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Instruction capture on the accepted ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= 32'h0000_0000;
        end else if (capture) begin
            instr_reg <= imem_rdata;
        end
    end

    // PC and retire counter advance together when execution completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= RESET_PC;
            retired_reg <= 32'h0000_0000;
        end else if (retire) begin
            pc_reg      <= next_pc;
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign retired_cnt = retired_reg;

endmodule
